// File: rtl/pipes.sv
// rtl/pipes.sv - shared commit-stage types, trap default and helpers
package pipes;

    localparam logic [31:0] TRAP_INSTR_DEFAULT = 32'h0000_006b;
    localparam logic [4:0]  REG_A0             = 5'd10;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        regwrite;
        logic [4:0]  dst;
        logic [63:0] result;
        logic        is_mem;
        logic [63:0] addr;
    } commit_lane_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } commit_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/commit_lane_sel.sv
// rtl/commit_lane_sel.sv - per-lane write-conflict and x10-source priority selection
module commit_lane_sel import pipes::*; #(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [COMMIT_WIDTH-1:0]   eff_i,
    input  logic [COMMIT_WIDTH-1:0]   regwrite_i,
    input  logic [COMMIT_WIDTH*5-1:0] dst_i,
    input  logic [COMMIT_WIDTH*8-1:0] result_lo_i,
    input  logic [7:0]                a0_lo_i,
    input  logic [COMMIT_WIDTH-1:0]   trap_i,
    output logic [COMMIT_WIDTH-1:0]   wen_o,
    output logic                      trap_hit_o,
    output logic [1:0]                trap_idx_o,
    output logic [7:0]                trap_code_o
);

    localparam int W = COMMIT_WIDTH;

    logic [7:0] x10_run;

    // A lane writes the regfile only if no younger effective lane hits the same register
    always_comb begin
        wen_o = '0;
        for (int i = 0; i < W; i++) begin
            wen_o[i] = eff_i[i] && regwrite_i[i] && (dst_i[i*5 +: 5] != 5'd0);
            for (int j = i + 1; j < W; j++) begin
                if (eff_i[j] && regwrite_i[j] && (dst_i[j*5 +: 5] == dst_i[i*5 +: 5])) begin
                    wen_o[i] = 1'b0;
                end
            end
        end
    end

    // Walk lanes oldest-first, tracking x10 so the trap sees older same-cycle writes
    always_comb begin
        x10_run     = a0_lo_i;
        trap_hit_o  = 1'b0;
        trap_idx_o  = 2'd0;
        trap_code_o = a0_lo_i;
        for (int i = 0; i < W; i++) begin
            if (!trap_hit_o) begin
                if (trap_i[i]) begin
                    trap_hit_o  = 1'b1;
                    trap_idx_o  = 2'(i);
                    trap_code_o = x10_run;
                end else if (eff_i[i] && regwrite_i[i] && (dst_i[i*5 +: 5] == REG_A0)) begin
                    x10_run = result_lo_i[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - multi-lane retire stage with trap halt; COMMIT_MMIO_SKIP_EN enables cmt_skip
module commit_unit import pipes::*; #(
    parameter int          COMMIT_WIDTH = 2,
    parameter logic [31:0] TRAP_INSTR   = TRAP_INSTR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COMMIT_WIDTH-1:0]    in_valid,
    input  logic [COMMIT_WIDTH*64-1:0] in_pc,
    input  logic [COMMIT_WIDTH*32-1:0] in_instr,
    input  logic [COMMIT_WIDTH-1:0]    in_regwrite,
    input  logic [COMMIT_WIDTH*5-1:0]  in_dst,
    input  logic [COMMIT_WIDTH*64-1:0] in_result,
    input  logic [COMMIT_WIDTH-1:0]    in_is_mem,
    input  logic [COMMIT_WIDTH*64-1:0] in_addr,
    input  logic [63:0]                a0_value,
    output logic [COMMIT_WIDTH-1:0]    rf_wen,
    output logic [COMMIT_WIDTH*5-1:0]  rf_wdest,
    output logic [COMMIT_WIDTH*64-1:0] rf_wdata,
    output logic [COMMIT_WIDTH*5-1:0]  fwd_dst,
    output logic [COMMIT_WIDTH*64-1:0] fwd_data,
    output logic [COMMIT_WIDTH-1:0]    cmt_valid,
    output logic [COMMIT_WIDTH*64-1:0] cmt_pc,
    output logic [COMMIT_WIDTH*32-1:0] cmt_instr,
    output logic [COMMIT_WIDTH-1:0]    cmt_skip,
    output logic [COMMIT_WIDTH-1:0]    cmt_wen,
    output logic [COMMIT_WIDTH*5-1:0]  cmt_wdest,
    output logic [COMMIT_WIDTH*64-1:0] cmt_wdata,
    output logic                       trap_valid,
    output logic [7:0]                 trap_code,
    output logic [63:0]                trap_pc,
    output logic [63:0]                cycle_cnt,
    output logic [63:0]                instr_cnt,
    output logic                       halted
);

    localparam int W = COMMIT_WIDTH;

    commit_state_t    state_q;
    commit_lane_t     lane_in [W];
    logic [W-1:0]     is_trap;
    logic [W-1:0]     eff;
    logic [W-1:0]     wen_sel;
    logic [W*8-1:0]   result_lo;
    logic             trap_hit;
    logic [1:0]       trap_idx;
    logic [7:0]       trap_code_sel;
    logic [63:0]      trap_pc_sel;
    logic [3:0]       eff4;
    logic [W-1:0]     skip_d;
    logic             lane_unused;

    logic [W-1:0]     cmt_valid_q;
    logic [W*64-1:0]  cmt_pc_q;
    logic [W*32-1:0]  cmt_instr_q;
    logic [W-1:0]     cmt_skip_q;
    logic [W-1:0]     cmt_wen_q;
    logic [W*5-1:0]   cmt_wdest_q;
    logic [W*64-1:0]  cmt_wdata_q;
    logic             trap_valid_q;
    logic             halted_q;
    logic [7:0]       trap_code_q;
    logic [63:0]      trap_pc_q;
    logic [63:0]      cycle_q;
    logic [63:0]      instr_q;

    // Unpack the flat lane buses into per-lane records
    always_comb begin
        result_lo = '0;
        for (int i = 0; i < W; i++) begin
            lane_in[i]          = '0;
            lane_in[i].pc       = in_pc[i*64 +: 64];
            lane_in[i].instr    = in_instr[i*32 +: 32];
            lane_in[i].regwrite = in_regwrite[i];
            lane_in[i].dst      = in_dst[i*5 +: 5];
            lane_in[i].result   = in_result[i*64 +: 64];
            lane_in[i].is_mem   = in_is_mem[i];
            lane_in[i].addr     = in_addr[i*64 +: 64];
            result_lo[i*8 +: 8] = lane_in[i].result[7:0];
        end
    end

    // Effective lanes: valid, running, not in reset, and not behind a trap in this group
    always_comb begin
        logic older_trap;
        older_trap = 1'b0;
        is_trap    = '0;
        eff        = '0;
        for (int i = 0; i < W; i++) begin
            is_trap[i] = in_valid[i] && (lane_in[i].instr == TRAP_INSTR);
            eff[i]     = in_valid[i] && !reset && (state_q == ST_RUN) && !older_trap;
            older_trap = older_trap || is_trap[i];
        end
    end

    commit_lane_sel #(
        .COMMIT_WIDTH (W)
    ) u_lane_sel (
        .eff_i       (eff),
        .regwrite_i  (in_regwrite),
        .dst_i       (in_dst),
        .result_lo_i (result_lo),
        .a0_lo_i     (a0_value[7:0]),
        .trap_i      (eff & is_trap),
        .wen_o       (wen_sel),
        .trap_hit_o  (trap_hit),
        .trap_idx_o  (trap_idx),
        .trap_code_o (trap_code_sel)
    );

    // Pick the pc of the lane that carries the trap
    always_comb begin
        trap_pc_sel = '0;
        for (int i = 0; i < W; i++) begin
            if (2'(i) == trap_idx) begin
                trap_pc_sel = lane_in[i].pc;
            end
        end
    end

    // MMIO skip marks stores/loads below the 2 GiB boundary when the feature is built in
    always_comb begin
        skip_d = '0;
`ifdef COMMIT_MMIO_SKIP_EN
        for (int i = 0; i < W; i++) begin
            skip_d[i] = lane_in[i].is_mem && !lane_in[i].addr[31];
        end
`endif
    end

    // Sink for input bits that only matter in some builds
    always_comb begin
        lane_unused = ^a0_value[63:8];
        for (int i = 0; i < W; i++) begin
            lane_unused = lane_unused ^ lane_in[i].is_mem ^ (^lane_in[i].addr);
        end
    end

    // Forwarding exposes every effective register-writing lane, even x0 or overridden ones
    always_comb begin
        fwd_dst = '0;
        for (int i = 0; i < W; i++) begin
            fwd_dst[i*5 +: 5] = (eff[i] && lane_in[i].regwrite) ? lane_in[i].dst : 5'd0;
        end
    end

    assign eff4     = 4'(eff);
    assign rf_wen   = wen_sel;
    assign rf_wdest = in_dst;
    assign rf_wdata = in_result;
    assign fwd_data = in_result;

    // Commit record: one-cycle delayed copy of each lane for the tracer
    always_ff @(posedge clk) begin
        if (reset) begin
            cmt_valid_q <= '0;
            cmt_pc_q    <= '0;
            cmt_instr_q <= '0;
            cmt_skip_q  <= '0;
            cmt_wen_q   <= '0;
            cmt_wdest_q <= '0;
            cmt_wdata_q <= '0;
        end else begin
            cmt_valid_q <= eff;
            cmt_skip_q  <= skip_d;
            for (int i = 0; i < W; i++) begin
                cmt_pc_q[i*64 +: 64]    <= lane_in[i].pc;
                cmt_instr_q[i*32 +: 32] <= lane_in[i].instr;
                cmt_wen_q[i]            <= lane_in[i].regwrite;
                cmt_wdest_q[i*5 +: 5]   <= lane_in[i].dst;
                cmt_wdata_q[i*64 +: 64] <= lane_in[i].result;
            end
        end
    end

    // Run/trap/halt sequencing with the cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            trap_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            trap_code_q  <= '0;
            trap_pc_q    <= '0;
            cycle_q      <= '0;
            instr_q      <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycle_q <= cycle_q + 64'd1;
                    instr_q <= instr_q + 64'(popcount4(eff4));
                    if (trap_hit) begin
                        state_q      <= ST_TRAP;
                        trap_valid_q <= 1'b1;
                        halted_q     <= 1'b1;
                        trap_code_q  <= trap_code_sel;
                        trap_pc_q    <= trap_pc_sel;
                    end
                end
                ST_TRAP: begin
                    state_q      <= ST_HALT;
                    trap_valid_q <= 1'b0;
                    halted_q     <= 1'b1;
                end
                ST_HALT: begin
                    trap_valid_q <= 1'b0;
                    halted_q     <= 1'b1;
                end
                default: begin
                    state_q      <= ST_HALT;
                    trap_valid_q <= 1'b0;
                    halted_q     <= 1'b1;
                end
            endcase
        end
    end

    assign cmt_valid  = cmt_valid_q;
    assign cmt_pc     = cmt_pc_q;
    assign cmt_instr  = cmt_instr_q;
    assign cmt_skip   = cmt_skip_q;
    assign cmt_wen    = cmt_wen_q;
    assign cmt_wdest  = cmt_wdest_q;
    assign cmt_wdata  = cmt_wdata_q;
    assign trap_valid = trap_valid_q;
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;
    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - randomized and directed self-checking bench for commit_unit
module tb_commit_unit;

    localparam int          W    = 2;
    localparam logic [31:0] TRAP = 32'h0000_006b;

    logic              clk = 1'b0;
    logic              reset;
    logic [W-1:0]      in_valid, in_regwrite, in_is_mem;
    logic [W*64-1:0]   in_pc, in_result, in_addr;
    logic [W*32-1:0]   in_instr;
    logic [W*5-1:0]    in_dst;
    logic [63:0]       a0_value;
    logic [W-1:0]      rf_wen, cmt_valid, cmt_skip, cmt_wen;
    logic [W*5-1:0]    rf_wdest, fwd_dst, cmt_wdest;
    logic [W*64-1:0]   rf_wdata, fwd_data, cmt_pc, cmt_wdata;
    logic [W*32-1:0]   cmt_instr;
    logic              trap_valid, halted;
    logic [7:0]        trap_code;
    logic [63:0]       trap_pc, cycle_cnt, instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int                m_phase;
    longint unsigned   m_cycles, m_instrs;
    logic [63:0]       m_trap_pc;
    logic [7:0]        m_trap_code, m_code;
    logic [W-1:0]      m_eff, m_wen;
    logic [W*5-1:0]    m_fwd;
    bit                m_hit;
    int                m_hit_lane;
    logic [W-1:0]      e_valid, e_skip, e_wen;
    logic [W*64-1:0]   e_pc, e_wdata;
    logic [W*32-1:0]   e_instr;
    logic [W*5-1:0]    e_wdest;

    commit_unit #(.COMMIT_WIDTH(W), .TRAP_INSTR(TRAP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_regwrite(in_regwrite), .in_dst(in_dst), .in_result(in_result), .in_is_mem(in_is_mem),
        .in_addr(in_addr), .a0_value(a0_value), .rf_wen(rf_wen), .rf_wdest(rf_wdest),
        .rf_wdata(rf_wdata), .fwd_dst(fwd_dst), .fwd_data(fwd_data), .cmt_valid(cmt_valid),
        .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .cmt_skip(cmt_skip), .cmt_wen(cmt_wen),
        .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .trap_valid(trap_valid),
        .trap_code(trap_code), .trap_pc(trap_pc), .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of the group: retire oldest-first, stop after a trap, last writer of a register wins
    task automatic model_comb();
        int          last_writer [32];
        logic [63:0] x10;
        bit          stop;
        m_eff = '0; m_wen = '0; m_fwd = '0; m_hit = 0; m_hit_lane = 0;
        x10 = a0_value; m_code = a0_value[7:0]; stop = 0;
        for (int r = 0; r < 32; r++) last_writer[r] = -1;
        if (!reset && m_phase == 0) begin
            for (int i = 0; i < W; i++) begin
                if (!stop && in_valid[i]) begin
                    m_eff[i] = 1'b1;
                    if (in_instr[i*32 +: 32] == TRAP) begin
                        m_hit = 1; m_hit_lane = i; m_code = x10[7:0]; stop = 1;
                    end else if (in_regwrite[i] && in_dst[i*5 +: 5] == 5'd10) begin
                        x10 = in_result[i*64 +: 64];
                    end
                    if (in_regwrite[i]) begin
                        last_writer[in_dst[i*5 +: 5]] = i;
                        m_fwd[i*5 +: 5] = in_dst[i*5 +: 5];
                    end
                end
            end
        end
        for (int i = 0; i < W; i++) begin
            if (m_eff[i] && in_regwrite[i] && in_dst[i*5 +: 5] != 5'd0 &&
                last_writer[in_dst[i*5 +: 5]] == i) m_wen[i] = 1'b1;
        end
    endtask

    task automatic model_seq();
        if (reset) begin
            m_phase = 0; m_cycles = 0; m_instrs = 0;
            e_valid = '0; e_skip = '0; e_wen = '0; e_pc = '0; e_wdata = '0; e_instr = '0; e_wdest = '0;
        end else begin
            e_valid = m_eff; e_pc = in_pc; e_instr = in_instr; e_wen = in_regwrite;
            e_wdest = in_dst; e_wdata = in_result;
            for (int i = 0; i < W; i++) begin
`ifdef COMMIT_MMIO_SKIP_EN
                e_skip[i] = in_is_mem[i] && !in_addr[i*64 + 31];
`else
                e_skip[i] = 1'b0;
`endif
            end
            if (m_phase == 0) begin
                m_cycles++;
                m_instrs += 64'($countones(m_eff));
                if (m_hit) begin
                    m_phase = 1;
                    m_trap_pc = in_pc[m_hit_lane*64 +: 64];
                    m_trap_code = m_code;
                end
            end else begin
                m_phase = 2;
            end
        end
    endtask

    // Called at a negedge with inputs set; returns at the following negedge
    task automatic run_cycle();
        #1;
        model_comb();
        chk("rf_wen", 128'(rf_wen), 128'(m_wen));
        chk("fwd_dst", 128'(fwd_dst), 128'(m_fwd));
        chk("rf_wdest", 128'(rf_wdest), 128'(in_dst));
        chk("rf_wdata", 128'(rf_wdata), 128'(in_result));
        @(posedge clk);
        #1;
        model_seq();
        chk("cmt_valid", 128'(cmt_valid), 128'(e_valid));
        chk("cmt_pc", 128'(cmt_pc), 128'(e_pc));
        chk("cmt_instr", 128'(cmt_instr), 128'(e_instr));
        chk("cmt_skip", 128'(cmt_skip), 128'(e_skip));
        chk("cmt_wen", 128'(cmt_wen), 128'(e_wen));
        chk("cmt_wdest", 128'(cmt_wdest), 128'(e_wdest));
        chk("cmt_wdata", 128'(cmt_wdata), 128'(e_wdata));
        chk("trap_valid", 128'(trap_valid), 128'(m_phase == 1));
        chk("halted", 128'(halted), 128'(m_phase != 0));
        chk("cycle_cnt", 128'(cycle_cnt), 128'(m_cycles));
        chk("instr_cnt", 128'(instr_cnt), 128'(m_instrs));
        if (m_phase == 1) begin
            chk("trap_pc", 128'(trap_pc), 128'(m_trap_pc));
            chk("trap_code", 128'(trap_code), 128'(m_trap_code));
        end
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic v, input logic [63:0] pc, input logic [31:0] ins,
                            input logic rw, input logic [4:0] dst, input logic [63:0] res,
                            input logic mem, input logic [63:0] addr);
        in_valid[i] = v; in_pc[i*64 +: 64] = pc; in_instr[i*32 +: 32] = ins;
        in_regwrite[i] = rw; in_dst[i*5 +: 5] = dst; in_result[i*64 +: 64] = res;
        in_is_mem[i] = mem; in_addr[i*64 +: 64] = addr;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < W; i++) set_lane(i, 1'b0, 64'd0, 32'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic rand_lanes(input int trap_pct);
        logic [31:0] ins;
        for (int i = 0; i < W; i++) begin
            ins = $urandom;
            if (ins == TRAP) ins = 32'h0000_0013;
            if (int'($urandom_range(0, 99)) < trap_pct) ins = TRAP;
            set_lane(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, ins,
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 6)),
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end
        a0_value = {$urandom, $urandom};
    endtask

    initial begin
        longint unsigned base;
        m_phase = 0; m_cycles = 0; m_instrs = 0; m_trap_pc = '0; m_trap_code = '0;
        a0_value = '0;
        clear_lanes();

        // reset with live inputs: combinational outputs held at zero
        reset = 1'b1;
        rand_lanes(50);
        in_valid = 2'b11;
        run_cycle();
        run_cycle();
        reset = 1'b0;

        // two writers of x5: only the younger reaches the regfile
        clear_lanes();
        set_lane(0, 1'b1, 64'h1000, 32'h0070_0293, 1'b1, 5'd5, 64'd7, 1'b0, 64'd0);
        set_lane(1, 1'b1, 64'h1004, 32'h0090_0293, 1'b1, 5'd5, 64'd9, 1'b0, 64'd0);
        base = m_instrs;
        #1;
        chk("r29_wen", 128'(rf_wen), 128'(2'b10));
        chk("r29_wdata1", 128'(rf_wdata[127:64]), 128'(64'd9));
        run_cycle();
        chk("r29_cmt_valid", 128'(cmt_valid), 128'(2'b11));
        chk("r29_instr_cnt", 128'(instr_cnt), 128'(base + 2));

        // lane0 invalid with trap garbage, lane1 writes x0
        set_lane(0, 1'b0, 64'hdead, TRAP, 1'b1, 5'd5, 64'hbad, 1'b1, 64'd0);
        set_lane(1, 1'b1, 64'h1008, 32'h0000_0013, 1'b1, 5'd0, 64'd3, 1'b0, 64'd0);
        base = m_instrs;
        #1;
        chk("r34_wen", 128'(rf_wen), 128'(2'b00));
        chk("r34_fwd1", 128'(fwd_dst[9:5]), 128'(5'd0));
        run_cycle();
        chk("r34_instr_cnt", 128'(instr_cnt), 128'(base + 1));
        chk("r34_halted", 128'(halted), 128'(1'b0));

        // MMIO skip marking
        set_lane(0, 1'b1, 64'h2000, 32'h0000_3003, 1'b1, 5'd7, 64'd1, 1'b1, 64'h1000_0000);
        set_lane(1, 1'b1, 64'h2004, 32'h0000_3003, 1'b1, 5'd8, 64'd2, 1'b1, 64'h8000_0000);
        run_cycle();
`ifdef COMMIT_MMIO_SKIP_EN
        chk("r32_skip", 128'(cmt_skip), 128'(2'b01));
`else
        chk("r32_skip", 128'(cmt_skip), 128'(2'b00));
`endif

        // random traffic without traps
        for (int n = 0; n < 150; n++) begin
            rand_lanes(0);
            run_cycle();
        end

        // trap in lane0 squashes the younger write
        set_lane(0, 1'b1, 64'h3000, TRAP, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        set_lane(1, 1'b1, 64'h3004, 32'h0010_0313, 1'b1, 5'd6, 64'd1, 1'b0, 64'd0);
        base = m_instrs;
        #1;
        chk("r31_wen", 128'(rf_wen), 128'(2'b00));
        run_cycle();
        chk("r31_instr_cnt", 128'(instr_cnt), 128'(base + 1));
        chk("r31_cmt_valid", 128'(cmt_valid), 128'(2'b01));
        chk("r31_trap_valid", 128'(trap_valid), 128'(1'b1));
        chk("r31_trap_pc", 128'(trap_pc), 128'(64'h3000));
        for (int n = 0; n < 10; n++) begin
            rand_lanes(30);
            run_cycle();
        end
        chk("r31_halted", 128'(halted), 128'(1'b1));

        // reset out of HALT, then trap whose code comes from an older x10 write
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        chk("r33_cycle_zero", 128'(cycle_cnt), 128'(64'd0));
        set_lane(0, 1'b1, 64'h4000, 32'h0000_0513, 1'b1, 5'd10, 64'h0, 1'b0, 64'd0);
        set_lane(1, 1'b1, 64'h4004, TRAP, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        a0_value = 64'd5;
        run_cycle();
        chk("r30_trap_valid", 128'(trap_valid), 128'(1'b1));
        chk("r30_trap_code", 128'(trap_code), 128'(8'd0));
        chk("r30_trap_pc", 128'(trap_pc), 128'(64'h4004));
        for (int n = 0; n < 5; n++) begin
            rand_lanes(20);
            run_cycle();
        end
        chk("r30_halted", 128'(halted), 128'(1'b1));

        // 100 idle cycles then a trap
        reset = 1'b1;
        clear_lanes();
        run_cycle();
        reset = 1'b0;
        for (int n = 0; n < 100; n++) run_cycle();
        set_lane(0, 1'b1, 64'h5000, TRAP, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        run_cycle();
        chk("r33_cycle_101", 128'(cycle_cnt), 128'(64'd101));
        clear_lanes();
        for (int n = 0; n < 4; n++) run_cycle();
        chk("r33_frozen", 128'(cycle_cnt), 128'(64'd101));

        // reset landing on the TRAP cycle
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        set_lane(1, 1'b1, 64'h6004, TRAP, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        run_cycle();
        reset = 1'b1;
        clear_lanes();
        run_cycle();
        reset = 1'b0;
        rand_lanes(0);
        run_cycle();
        chk("mid_trap_reset", 128'(halted), 128'(1'b0));

        // random soak with occasional traps and resets
        for (int n = 0; n < 400; n++) begin
            rand_lanes(5);
            reset = ($urandom_range(0, 99) < 3);
            run_cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 Parameter COMMIT_WIDTH, default 2, number of commit lanes (1..4); lane 0 oldest.
REQ-002 Parameter TRAP_INSTR, default 32'h0000_006b, instruction word that ends simulation.
REQ-003 clk  in  1  single clock; reset  in  1  reset is synchronous and active-high.
REQ-004 in_valid  in  W  per-lane instruction retiring this cycle.
REQ-005 in_pc[W]  in  64; in_instr[W]  in  32; in_regwrite  in  W; in_dst[W]  in  5; in_result[W]  in  64.
REQ-006 in_is_mem  in  W  lane is load/store; in_addr[W]  in  64  effective address.
REQ-007 a0_value  in  64  current regfile x10 before this cycle's writes.
REQ-008 rf_wen  out  W; rf_wdest[W]  out  5; rf_wdata[W]  out  64  regfile write ports (combinational).
REQ-009 fwd_dst[W]  out  5; fwd_data[W]  out  64  writeback forwarding (combinational).
REQ-010 cmt_valid  out  W; cmt_pc, cmt_instr, cmt_skip, cmt_wen, cmt_wdest, cmt_wdata  out  per lane  registered commit record.
REQ-011 trap_valid  out  1; trap_code  out  8; trap_pc  out  64; cycle_cnt  out  64; instr_cnt  out  64; halted  out  1.

Function
REQ-012 Effective lane mask eff[i] SHALL be in_valid[i] AND state==RUN AND no older lane j<i in this cycle is a valid TRAP_INSTR.
REQ-013 rf_wen[i] SHALL be eff[i] AND in_regwrite[i] AND in_dst[i]!=0 AND no younger effective lane writes the same dst.
REQ-014 fwd_dst[i] SHALL equal in_dst[i] when eff[i]&in_regwrite[i], else 0; fwd_data[i]=in_result[i].
REQ-015 cmt_* SHALL register lane inputs with latency 1 cycle; cmt_valid[i]=eff[i] of previous cycle; cmt_wen carries raw in_regwrite.
REQ-016 FSM states RUN, TRAP, HALT; RUN->TRAP when any eff lane carries TRAP_INSTR; TRAP->HALT unconditionally next cycle; HALT sticky until reset.
REQ-017 trap_valid SHALL be 1 exactly while in TRAP (same cycle as trap lane's cmt_valid); trap_pc = that lane's pc.
REQ-018 trap_code SHALL be low 8 bits of x10 as seen by the trap: youngest older eff lane writing x10 in the same cycle, else a0_value.
REQ-019 cycle_cnt SHALL increment by 1 every cycle in RUN, including the trap cycle; frozen in TRAP/HALT; 64-bit wrap.
REQ-020 instr_cnt SHALL add popcount(eff) each cycle; trap instruction counts; lanes after it do not; 64-bit wrap.
REQ-021 halted SHALL be 1 in TRAP and HALT; upstream freezes on it.
REQ-022 Input lanes with in_valid=0 SHALL be ignored regardless of other fields, including non-contiguous valid patterns.

Reset
REQ-023 On reset: state RUN; cmt_valid, trap_valid, halted, cycle_cnt, instr_cnt, all cmt_* fields = 0; reset mid-TRAP or in HALT returns to RUN next cycle.
REQ-024 Combinational outputs SHALL be forced to 0 (rf_wen, fwd_dst) while reset is high.

Configuration
REQ-025 Macro COMMIT_MMIO_SKIP_EN defined: cmt_skip[i] = in_is_mem[i] AND in_addr[i][31]==0, registered with lane.
REQ-026 Macro undefined: cmt_skip SHALL be constant 0; all other behaviour unchanged.

Structure
REQ-027 Package pipes SHALL hold commit_lane_t (pc, instr, regwrite, dst, result, is_mem, addr) and commit_state_t enum; TRAP_INSTR default in common.
REQ-028 One sub-module commit_lane_sel: per-lane write-conflict and x10-source priority selection; FSM and counters stay in commit_unit.

Verification
REQ-029 W=2, lane0 addi x5<-7, lane1 addi x5<-9 -> rf_wen=2'b10, x5=9; instr_cnt+=2; next cycle cmt_valid=2'b11.
REQ-030 lane0 writes x10=0, lane1 TRAP_INSTR, a0_value=5 -> next cycle trap_valid=1, trap_code=0, trap_pc=lane1 pc; then halted=1 forever.
REQ-031 lane0 TRAP_INSTR, lane1 valid write x6 -> rf_wen=2'b00, instr_cnt+=1, cmt_valid=2'b01.
REQ-032 With COMMIT_MMIO_SKIP_EN, load addr 0x1000_0000 -> cmt_skip=1; addr 0x8000_0000 -> 0; macro off -> always 0.
REQ-033 100 idle cycles then trap -> cycle_cnt=101 frozen; reset during HALT -> counters 0, RUN, new commits accepted.
REQ-034 in_valid=2'b10, lane0 fields garbage, lane1 write x0 -> rf_wen=0, fwd_dst[1]=0, instr_cnt+=1.
